// File: rtl/mc_cmd_arbiter.sv
// Two-requester round-robin command scheduler for the memory controller command port.
// Read returns are steered back to their issuer through an in-order requester-id FIFO.
module mc_cmd_arbiter #(
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 16,
  parameter int CMD_W     = 34
) (
  input  logic              clk,
  input  logic              power_on_rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CMD_W-1:0]  req0_command,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CMD_W-1:0]  req1_command,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [7:0]        ba_cmd_pm,
  output logic [CMD_W-1:0]  command,
  output logic [DATA_W-1:0] write_data,
  output logic              valid,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_data_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata0_valid,
  output logic              rdata1_valid,
  output logic              tag_full,
  output logic              orphan_err
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  logic              held0_r, held1_r;
  logic [CMD_W-1:0]  cmd0_r, cmd1_r;
  logic [DATA_W-1:0] wdata0_r, wdata1_r;
  logic              rr_r;
  logic [TAG_DEPTH-1:0] tag_mem_r;
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r, count_nxt_s;
  logic              tag_full_r, orphan_r;
  logic [CMD_W-1:0]  command_r;
  logic [DATA_W-1:0] write_data_r, rdata_r;
  logic              valid_r, rdata0_valid_r, rdata1_valid_r;

  logic              elig0_s, elig1_s, grant0_s, grant1_s, grant_s;
  logic [CMD_W-1:0]  win_cmd_s;
  logic [DATA_W-1:0] win_wdata_s;
  logic              push_s, pop_s;

  // Eligibility, round-robin grant and winner selection; rr_r names the requester holding priority.
  always_comb begin
    elig0_s     = held0_r & ba_cmd_pm[cmd0_r[2:0]] & (~cmd0_r[31] | ~tag_full_r);
    elig1_s     = held1_r & ba_cmd_pm[cmd1_r[2:0]] & (~cmd1_r[31] | ~tag_full_r);
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    win_cmd_s   = cmd0_r;
    win_wdata_s = wdata0_r;
    if (elig0_s && elig1_s) begin
      grant0_s = ~rr_r;
      grant1_s = rr_r;
    end else begin
      grant0_s = elig0_s;
      grant1_s = elig1_s;
    end
    if (grant1_s) begin
      win_cmd_s   = cmd1_r;
      win_wdata_s = wdata1_r;
    end else begin
      win_cmd_s   = cmd0_r;
      win_wdata_s = wdata0_r;
    end
    grant_s = grant0_s | grant1_s;
    push_s  = grant_s & win_cmd_s[31];
    pop_s   = read_data_valid & (count_r != {CW{1'b0}});
  end

  // Outstanding-read count; a push and pop in the same cycle cancel.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  assign req0_ready = ~held0_r | grant0_s;
  assign req1_ready = ~held1_r | grant1_s;

  // Per-requester holding registers; a same-cycle refill wins over the grant clear.
  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      held0_r  <= 1'b0;
      held1_r  <= 1'b0;
      cmd0_r   <= {CMD_W{1'b0}};
      cmd1_r   <= {CMD_W{1'b0}};
      wdata0_r <= {DATA_W{1'b0}};
      wdata1_r <= {DATA_W{1'b0}};
    end else begin
      if (req0_valid && req0_ready) begin
        held0_r  <= 1'b1;
        cmd0_r   <= req0_command;
        wdata0_r <= req0_wdata;
      end else if (grant0_s) begin
        held0_r  <= 1'b0;
      end
      if (req1_valid && req1_ready) begin
        held1_r  <= 1'b1;
        cmd1_r   <= req1_command;
        wdata1_r <= req1_wdata;
      end else if (grant1_s) begin
        held1_r  <= 1'b0;
      end
    end
  end

  // Issue register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      valid_r      <= 1'b0;
      command_r    <= {CMD_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
      rr_r         <= 1'b0;
    end else begin
      valid_r      <= grant_s;
      command_r    <= grant_s ? win_cmd_s : {CMD_W{1'b0}};
      write_data_r <= (grant_s && !win_cmd_s[31]) ? win_wdata_s : {DATA_W{1'b0}};
      if (grant_s) begin
        rr_r <= grant0_s;
      end
    end
  end

  // Requester-id FIFO for outstanding reads and the registered return path.
  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      tag_mem_r      <= {TAG_DEPTH{1'b0}};
      wr_ptr_r       <= {PW{1'b0}};
      rd_ptr_r       <= {PW{1'b0}};
      count_r        <= {CW{1'b0}};
      tag_full_r     <= 1'b0;
      orphan_r       <= 1'b0;
      rdata_r        <= {DATA_W{1'b0}};
      rdata0_valid_r <= 1'b0;
      rdata1_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= grant1_s;
        wr_ptr_r            <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
        rdata_r  <= read_data;
      end
      count_r        <= count_nxt_s;
      tag_full_r     <= (count_nxt_s == CW'(TAG_DEPTH));
      rdata0_valid_r <= pop_s & ~tag_mem_r[rd_ptr_r];
      rdata1_valid_r <= pop_s & tag_mem_r[rd_ptr_r];
      if (read_data_valid && !pop_s) begin
        orphan_r <= 1'b1;
      end
    end
  end

  assign command      = command_r;
  assign write_data   = write_data_r;
  assign valid        = valid_r;
  assign rdata        = rdata_r;
  assign rdata0_valid = rdata0_valid_r;
  assign rdata1_valid = rdata1_valid_r;
  assign tag_full     = tag_full_r;
  assign orphan_err   = orphan_r;

endmodule

// File: tb/tb_mc_cmd_arbiter.sv
// Directed bench for mc_cmd_arbiter: hand-computed expectations checked with immediate assertions.
module tb_mc_cmd_arbiter;
  localparam int DATA_W = 128;
  localparam int CMD_W  = 34;

  logic              clk = 1'b0;
  logic              power_on_rst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [CMD_W-1:0]  req0_command, req1_command, command;
  logic [DATA_W-1:0] req0_wdata, req1_wdata, write_data, read_data, rdata;
  logic [7:0]        ba_cmd_pm;
  logic              valid, read_data_valid, rdata0_valid, rdata1_valid, tag_full, orphan_err;

  int   n_vec = 0;
  int   n_err = 0;
  int   i0, i1;
  logic a0, a1;
  logic [CMD_W-1:0]  c0, c1;
  logic [DATA_W-1:0] d;

  always #5 clk = ~clk;

  mc_cmd_arbiter #(.DATA_W(128), .TAG_DEPTH(16), .CMD_W(34)) dut (
    .clk(clk), .power_on_rst(power_on_rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_command(req0_command), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_command(req1_command), .req1_wdata(req1_wdata),
    .ba_cmd_pm(ba_cmd_pm), .command(command), .write_data(write_data), .valid(valid),
    .read_data(read_data), .read_data_valid(read_data_valid), .rdata(rdata),
    .rdata0_valid(rdata0_valid), .rdata1_valid(rdata1_valid), .tag_full(tag_full), .orphan_err(orphan_err)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    power_on_rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; read_data_valid = 1'b0;
    ba_cmd_pm = 8'h00; read_data = '0;
    tick();
    tick();
    power_on_rst = 1'b0;
  endtask

  function automatic logic [CMD_W-1:0] mk(input logic [1:0] rank, input logic rw,
                                          input logic [7:0] tg, input logic [2:0] bank);
    return {rank, rw, 20'h5A5A5, tg, bank};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req0_command = '0; req1_command = '0;
    req0_wdata = '0; req1_wdata = '0;
    do_reset();
    chk("rst_valid", valid, 1'b0);
    chk("rst_command", command, '0);
    chk("rst_wdata", write_data, '0);
    chk("rst_rd0v", rdata0_valid, 1'b0);
    chk("rst_rd1v", rdata1_valid, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_full", tag_full, 1'b0);
    chk("rst_orphan", orphan_err, 1'b0);
    chk("rst_rdy0", req0_ready, 1'b1);
    chk("rst_rdy1", req1_ready, 1'b1);

    // single write to bank 2, then a return with no reads outstanding
    ba_cmd_pm = 8'h04;
    c0 = mk(2'd0, 1'b0, 8'h11, 3'd2);
    req0_command = c0;
    req0_wdata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    #1;
    chk("wr_lat_valid", valid, 1'b0);
    chk("wr_grant_rdy", req0_ready, 1'b1);
    tick();
    chk("wr_valid", valid, 1'b1);
    chk("wr_command", command, c0);
    chk("wr_wdata", write_data, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    tick();
    chk("wr_valid_off", valid, 1'b0);
    chk("wr_full", tag_full, 1'b0);
    read_data = 128'h1234;
    read_data_valid = 1'b1;
    tick();
    read_data_valid = 1'b0;
    chk("orph_set", orphan_err, 1'b1);
    chk("orph_rd0v", rdata0_valid, 1'b0);
    chk("orph_rd1v", rdata1_valid, 1'b0);
    tick();
    chk("orph_sticky", orphan_err, 1'b1);
    do_reset();
    chk("orph_clr", orphan_err, 1'b0);

    // five read pairs to bank 0: issue order r0[0],r1[0],r0[1],r1[1],...
    ba_cmd_pm = 8'hFF;
    req0_wdata = {4{32'h0BAD0BAD}};
    req1_wdata = {4{32'h0BADF00D}};
    i0 = 0; i1 = 0;
    for (int n = 0; n < 12; n++) begin
      req0_valid = (i0 < 5);
      req1_valid = (i1 < 5);
      req0_command = mk(2'd1, 1'b1, 8'(i0), 3'd0);
      req1_command = mk(2'd2, 1'b1, 8'(8'h10 + i1), 3'd0);
      #1;
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      tick();
      if (a0) i0++;
      if (a1) i1++;
      if (n >= 1 && n <= 10) begin
        chk("rr_valid", valid, 1'b1);
        if ((n - 1) % 2 == 0) chk("rr_cmd0", command, mk(2'd1, 1'b1, 8'((n - 1) / 2), 3'd0));
        else                  chk("rr_cmd1", command, mk(2'd2, 1'b1, 8'(8'h10 + (n - 1) / 2), 3'd0));
        chk("rr_rd_wdata", write_data, '0);
      end else if (n == 11) begin
        chk("rr_valid_off", valid, 1'b0);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      d = {4{32'hC0DE0000 + 32'(k)}};
      read_data = d;
      read_data_valid = 1'b1;
      tick();
      chk("ret_rd0v", rdata0_valid, (k % 2 == 0));
      chk("ret_rd1v", rdata1_valid, (k % 2 == 1));
      chk("ret_data", rdata, d);
    end
    read_data_valid = 1'b0;
    tick();
    chk("ret_idle0", rdata0_valid, 1'b0);
    chk("ret_idle1", rdata1_valid, 1'b0);
    chk("ret_hold", rdata, {4{32'hC0DE0009}});
    chk("ret_no_orph", orphan_err, 1'b0);
    read_data_valid = 1'b1;
    tick();
    read_data_valid = 1'b0;
    chk("ret_drained", orphan_err, 1'b1);
    do_reset();

    // bank-blocked read from req0 while req1 write to a ready bank goes first
    ba_cmd_pm = 8'h02;
    c0 = mk(2'd0, 1'b1, 8'h33, 3'd3);
    c1 = mk(2'd1, 1'b0, 8'h44, 3'd1);
    req0_command = c0; req1_command = c1;
    req1_wdata = {8{16'h1111}};
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("blk_rdy0", req0_ready, 1'b0);
    chk("blk_rdy1", req1_ready, 1'b1);
    tick();
    chk("blk_w_valid", valid, 1'b1);
    chk("blk_w_cmd", command, c1);
    chk("blk_w_wdata", write_data, {8{16'h1111}});
    for (int j = 0; j < 9; j++) begin
      tick();
      chk("blk_idle", valid, 1'b0);
      chk("blk_hold_rdy0", req0_ready, 1'b0);
    end
    ba_cmd_pm = 8'h0A;
    #1;
    chk("blk_rel_rdy0", req0_ready, 1'b1);
    tick();
    chk("blk_r_valid", valid, 1'b1);
    chk("blk_r_cmd", command, c0);
    chk("blk_r_wdata", write_data, '0);
    tick();
    chk("blk_off", valid, 1'b0);
    do_reset();

    // fill the tag FIFO from req1; the 17th read stalls
    ba_cmd_pm = 8'hFF;
    i1 = 0;
    for (int n = 0; n < 17; n++) begin
      req1_valid = (i1 < 17);
      req1_command = mk(2'd3, 1'b1, 8'(i1), 3'd0);
      #1;
      a1 = req1_valid & req1_ready;
      tick();
      if (a1) i1++;
      chk("fill_full", tag_full, (n == 16));
    end
    req1_valid = 1'b0;
    #1;
    chk("full_rdy1", req1_ready, 1'b0);
    chk("full_last_valid", valid, 1'b1);
    chk("full_last_cmd", command, mk(2'd3, 1'b1, 8'd15, 3'd0));
    tick();
    chk("full_stall", valid, 1'b0);
    chk("full_hold", tag_full, 1'b1);
    read_data = {16{8'hA5}};
    read_data_valid = 1'b1;
    tick();
    chk("full_pop_rd1v", rdata1_valid, 1'b1);
    chk("full_pop_rd0v", rdata0_valid, 1'b0);
    chk("full_pop_data", rdata, {16{8'hA5}});
    chk("full_pop_full", tag_full, 1'b0);
    chk("full_pop_rdy1", req1_ready, 1'b1);
    read_data = {16{8'h5A}};
    tick();
    read_data_valid = 1'b0;
    chk("pp_valid", valid, 1'b1);
    chk("pp_cmd", command, mk(2'd3, 1'b1, 8'd16, 3'd0));
    chk("pp_rd1v", rdata1_valid, 1'b1);
    chk("pp_data", rdata, {16{8'h5A}});
    chk("pp_full", tag_full, 1'b0);
    tick();
    chk("pp_full_after", tag_full, 1'b0);
    do_reset();

    // reset with two held commands and four reads outstanding
    ba_cmd_pm = 8'hFF;
    i0 = 0;
    for (int n = 0; n < 6; n++) begin
      req0_valid = (i0 < 4);
      req0_command = mk(2'd0, 1'b1, 8'(i0), 3'd0);
      #1;
      a0 = req0_valid & req0_ready;
      tick();
      if (a0) i0++;
    end
    ba_cmd_pm = 8'h00;
    req0_command = mk(2'd1, 1'b0, 8'h77, 3'd5);
    req1_command = mk(2'd1, 1'b0, 8'h88, 3'd6);
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("mid_rdy0", req0_ready, 1'b0);
    chk("mid_rdy1", req1_ready, 1'b0);
    power_on_rst = 1'b1;
    tick();
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_cmd", command, '0);
    chk("mid_rst_rdy0", req0_ready, 1'b1);
    chk("mid_rst_rdy1", req1_ready, 1'b1);
    power_on_rst = 1'b0;
    ba_cmd_pm = 8'hFF;
    tick();
    chk("mid_no_issue", valid, 1'b0);
    read_data_valid = 1'b1;
    tick();
    read_data_valid = 1'b0;
    chk("mid_orphan", orphan_err, 1'b1);
    chk("mid_no_rd0v", rdata0_valid, 1'b0);
    chk("mid_no_rd1v", rdata1_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
